// File: rtl/i2c_master_ctrl.sv
// Single-master I2C controller: START/STOP, 7-bit address + R/W, write/read bursts with ACK handling.
// Optional slave clock stretching is compiled in with `define I2C_CLK_STRETCH_EN (adds input scl_i).
module i2c_master_ctrl #(
    parameter int CLK_DIV = 250,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             rw,
    input  logic [6:0]       dev_addr,
    input  logic [CNT_W-1:0] nbytes,
    input  logic [7:0]       wr_data,
    output logic             wr_next,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             busy,
    output logic             done,
    output logic             ack_err,
    output logic             scl_oe,
    output logic             sda_oe,
`ifdef I2C_CLK_STRETCH_EN
    input  logic             scl_i,
`endif
    input  logic             sda_i
);
    localparam int               DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WR_BYTE,
        S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_STOP
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       ph_q, ph_d;
    logic [2:0]       bit_q, bit_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [7:0]       txb_q, txb_d;
    logic [6:0]       addr_q, addr_d;
    logic             rw_q, rw_d;
    logic [7:0]       rx_q, rx_d;
    logic [7:0]       rdd_q, rdd_d;
    logic             samp_q, samp_d;
    logic             ackerr_q, ackerr_d;

    logic       freeze, tick, slot_end, samp_pt;
    logic [7:0] addr_byte;

    assign addr_byte = {addr_q, rw_q};

    // Line drivers are pure decodes of state and phase, so SDA moves exactly on phase-0 entry.
    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (state_q)
            S_START:   sda_oe = ph_q[1];
            S_ADDR: begin
                scl_oe = !ph_q[1];
                sda_oe = !addr_byte[3'd7 - bit_q];
            end
            S_WR_BYTE: begin
                scl_oe = !ph_q[1];
                sda_oe = !txb_q[3'd7 - bit_q];
            end
            S_ADDR_ACK, S_WR_ACK, S_RD_BYTE: scl_oe = !ph_q[1];
            S_RD_ACK: begin
                scl_oe = !ph_q[1];
                sda_oe = (rem_q > ONE);
            end
            S_STOP: begin
                scl_oe = !ph_q[1];
                sda_oe = (ph_q != 2'd3);
            end
            default: ;
        endcase
    end

`ifdef I2C_CLK_STRETCH_EN
    // A slave holding SCL low while we release it stalls the whole timebase.
    assign freeze = (state_q != S_IDLE) && ph_q[1] && !scl_oe && !scl_i;
`else
    assign freeze = 1'b0;
`endif

    assign tick     = (div_q == DIV_MAX) && !freeze;
    assign slot_end = tick && (ph_q == 2'd3);
    assign samp_pt  = tick && (ph_q == 2'd2);
    assign busy     = (state_q != S_IDLE);
    assign ack_err  = ackerr_q;
    assign rd_data  = rd_valid ? rx_q : rdd_q;

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        ph_d     = ph_q;
        bit_d    = bit_q;
        rem_d    = rem_q;
        txb_d    = txb_q;
        addr_d   = addr_q;
        rw_d     = rw_q;
        rx_d     = rx_q;
        rdd_d    = rdd_q;
        samp_d   = samp_q;
        ackerr_d = ackerr_q;
        wr_next  = 1'b0;
        rd_valid = 1'b0;
        done     = 1'b0;

        if (state_q != S_IDLE && !freeze) begin
            div_d = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
            if (tick) ph_d = ph_q + 2'd1;
        end
        if (samp_pt) begin
            samp_d = sda_i;
            rx_d   = {rx_q[6:0], sda_i};
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d   = dev_addr;
                    rw_d     = rw;
                    rem_d    = nbytes;
                    txb_d    = wr_data;
                    div_d    = '0;
                    ph_d     = 2'd0;
                    bit_d    = 3'd0;
                    ackerr_d = 1'b0;
                    state_d  = S_START;
                end
            end
            S_START: if (slot_end) state_d = S_ADDR;
            S_ADDR: if (slot_end) begin
                if (bit_q == 3'd7) state_d = S_ADDR_ACK;
                bit_d = bit_q + 3'd1;
            end
            S_ADDR_ACK: if (slot_end) begin
                if (samp_q) begin
                    ackerr_d = 1'b1;
                    state_d  = S_STOP;
                end else if (rem_q == '0) state_d = S_STOP;
                else if (rw_q)            state_d = S_RD_BYTE;
                else                      state_d = S_WR_BYTE;
            end
            S_WR_BYTE: if (slot_end) begin
                if (bit_q == 3'd7) state_d = S_WR_ACK;
                bit_d = bit_q + 3'd1;
            end
            S_WR_ACK: if (slot_end) begin
                rem_d = rem_q - ONE;
                if (samp_q) begin
                    ackerr_d = 1'b1;
                    state_d  = S_STOP;
                end else if (rem_q > ONE) begin
                    wr_next = 1'b1;
                    txb_d   = wr_data;
                    state_d = S_WR_BYTE;
                end else state_d = S_STOP;
            end
            S_RD_BYTE: if (slot_end) begin
                if (bit_q == 3'd7) begin
                    rd_valid = 1'b1;
                    rdd_d    = rx_q;
                    state_d  = S_RD_ACK;
                end
                bit_d = bit_q + 3'd1;
            end
            S_RD_ACK: if (slot_end) begin
                rem_d   = rem_q - ONE;
                state_d = (rem_q > ONE) ? S_RD_BYTE : S_STOP;
            end
            S_STOP: if (slot_end) begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            ph_q     <= 2'd0;
            bit_q    <= 3'd0;
            rem_q    <= '0;
            txb_q    <= 8'h00;
            addr_q   <= 7'h00;
            rw_q     <= 1'b0;
            rx_q     <= 8'h00;
            rdd_q    <= 8'h00;
            samp_q   <= 1'b0;
            ackerr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            ph_q     <= ph_d;
            bit_q    <= bit_d;
            rem_q    <= rem_d;
            txb_q    <= txb_d;
            addr_q   <= addr_d;
            rw_q     <= rw_d;
            rx_q     <= rx_d;
            rdd_q    <= rdd_d;
            samp_q   <= samp_d;
            ackerr_q <= ackerr_d;
        end
    end
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: a bus-level I2C slave model decodes START/STOP/bits from the pins,
// and each transaction is checked against expectations computed from the protocol rules.
module tb_i2c_master_ctrl;
    localparam int CLK_DIV = 4;
    localparam int CNT_W   = 4;

    logic       clk = 1'b0;
    logic       reset, start, rw;
    logic [6:0] dev_addr;
    logic [3:0] nbytes;
    logic [7:0] wr_data, rd_data;
    logic       wr_next, rd_valid, busy, done, ack_err, scl_oe, sda_oe, sda_i;
    logic       slv_pull;
`ifdef I2C_CLK_STRETCH_EN
    logic       stretch = 1'b0;
    logic       scl_i;
    assign scl_i = !scl_oe && !stretch;
`endif
    assign sda_i = !sda_oe && !slv_pull;

    i2c_master_ctrl #(.CLK_DIV(CLK_DIV), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .rw(rw), .dev_addr(dev_addr),
        .nbytes(nbytes), .wr_data(wr_data), .wr_next(wr_next), .rd_data(rd_data),
        .rd_valid(rd_valid), .busy(busy), .done(done), .ack_err(ack_err),
        .scl_oe(scl_oe), .sda_oe(sda_oe),
`ifdef I2C_CLK_STRETCH_EN
        .scl_i(scl_i),
`endif
        .sda_i(sda_i)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [6:0] t_addr;
    logic       t_rw;
    int         t_nb;
    logic [7:0] t_data [16];
    logic       s_ack_addr = 1'b1;
    int         s_nack_at  = -1;
    logic [7:0] s_rd[$];
    logic [7:0] obs_bytes[$];
    logic       obs_macks[$];

    // Slave: samples on SCL rise, changes SDA only after SCL fall.
    initial begin : slave
        logic pscl, psda, scl_b, sda_b, is_rd, last_mack;
        logic [7:0] sh, cur;
        int r, byte_no;
        pscl = 1'b1; psda = 1'b1; is_rd = 1'b0; last_mack = 1'b1;
        sh = 8'h00; cur = 8'h00; r = 0; byte_no = 0; slv_pull = 1'b0;
        forever begin
            @(negedge clk);
            scl_b = !scl_oe;
            sda_b = sda_i;
            if (reset === 1'b1) begin
                r = 0; slv_pull = 1'b0;
            end else if (scl_b && pscl && psda && !sda_b) begin
                r = 0; byte_no = 0; slv_pull = 1'b0;
            end else if (scl_b && pscl && !psda && sda_b) begin
                r = 0; slv_pull = 1'b0;
            end else if (scl_b && !pscl) begin
                if (r < 8) sh = {sh[6:0], sda_b};
                if (r == 7) obs_bytes.push_back(sh);
                if (r == 8 && byte_no > 0 && is_rd) begin
                    last_mack = sda_b;
                    obs_macks.push_back(sda_b);
                end
                r++;
            end else if (!scl_b && pscl) begin
                if (r == 8) begin
                    if (byte_no == 0) begin
                        is_rd = sh[0];
                        slv_pull = s_ack_addr;
                    end else if (!is_rd) slv_pull = ((byte_no - 1) != s_nack_at);
                    else slv_pull = 1'b0;
                end else if (r == 9) begin
                    byte_no++;
                    r = 0;
                    if (is_rd && ((byte_no == 1) ? s_ack_addr : !last_mack) && s_rd.size() > 0) begin
                        cur = s_rd.pop_front();
                        slv_pull = !cur[7];
                    end else slv_pull = 1'b0;
                end else if (r >= 1 && r <= 7 && byte_no > 0 && is_rd) begin
                    slv_pull = !cur[7 - r];
                end
            end
            pscl = scl_b;
            psda = sda_b;
        end
    end

    task automatic do_txn(input string nm, input int ghost_at, input int stretch_at);
        int k, lat, widx, wrn, bx, exp_wrn, exp_lat;
        logic pend, exp_err;
        logic [7:0] rd_obs[$];
        logic [7:0] exp_b[$];
        obs_bytes.delete();
        obs_macks.delete();
        s_rd.delete();
        if (t_rw) for (int i = 0; i < t_nb; i++) s_rd.push_back(t_data[i]);
        @(negedge clk);
        dev_addr = t_addr; rw = t_rw; nbytes = 4'(t_nb); wr_data = t_data[0]; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wr_data = t_data[1]; widx = 2;
        lat = -1; wrn = 0; pend = 1'b0;
        for (k = 1; k <= 6000; k++) begin
            @(negedge clk);
            if (pend) begin
                wr_data = t_data[widx % 16];
                widx++;
                pend = 1'b0;
            end
            if (k == ghost_at) begin
                start = 1'b1; dev_addr = ~t_addr; rw = ~t_rw; nbytes = 4'd5;
            end else start = 1'b0;
`ifdef I2C_CLK_STRETCH_EN
            if (stretch_at > 0) stretch = (k >= stretch_at) && (k < stretch_at + 20);
`endif
            if (wr_next === 1'b1) begin wrn++; pend = 1'b1; end
            if (rd_valid === 1'b1) rd_obs.push_back(rd_data);
            if (k == 1) begin
                n_cmp++;
                if (busy !== 1'b1) begin n_bad++; $display("FAIL %s busy_rise: got %b want 1", nm, busy); end
            end
            if (done === 1'b1) begin lat = k; break; end
        end

        bx = 0; exp_err = 1'b0; exp_wrn = 0;
        if (!s_ack_addr) exp_err = 1'b1;
        else if (t_nb == 0) bx = 0;
        else if (t_rw) bx = t_nb;
        else if (s_nack_at >= 0 && s_nack_at < t_nb) begin
            bx = s_nack_at + 1; exp_err = 1'b1; exp_wrn = s_nack_at;
        end else begin
            bx = t_nb; exp_wrn = t_nb - 1;
        end
        // START + (address + data bytes) * 9 slots + STOP, each slot 4 phases.
        exp_lat = (8 + 36 * (1 + bx)) * CLK_DIV + ((stretch_at > 0) ? 20 : 0);
        exp_b.push_back({t_addr, t_rw});
        for (int i = 0; i < bx; i++) exp_b.push_back(t_data[i]);

        n_cmp++;
        if (lat != exp_lat) begin n_bad++; $display("FAIL %s done_latency: got %0d want %0d", nm, lat, exp_lat); end
        @(negedge clk);
        n_cmp++;
        if (ack_err !== exp_err) begin n_bad++; $display("FAIL %s ack_err: got %b want %b", nm, ack_err, exp_err); end
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL %s idle_after: busy=%b done=%b want 0 0", nm, busy, done); end
        n_cmp++;
        if (wrn != exp_wrn) begin n_bad++; $display("FAIL %s wr_next_count: got %0d want %0d", nm, wrn, exp_wrn); end
        n_cmp++;
        if (obs_bytes.size() != exp_b.size()) begin
            n_bad++; $display("FAIL %s bus_byte_count: got %0d want %0d", nm, obs_bytes.size(), exp_b.size());
        end else begin
            for (int i = 0; i < exp_b.size(); i++) begin
                n_cmp++;
                if (obs_bytes[i] !== exp_b[i]) begin n_bad++; $display("FAIL %s bus_byte[%0d]: got %h want %h", nm, i, obs_bytes[i], exp_b[i]); end
            end
        end
        n_cmp++;
        if (rd_obs.size() != (t_rw ? bx : 0)) begin
            n_bad++; $display("FAIL %s rd_valid_count: got %0d want %0d", nm, rd_obs.size(), t_rw ? bx : 0);
        end else if (t_rw) begin
            for (int i = 0; i < bx; i++) begin
                n_cmp++;
                if (rd_obs[i] !== t_data[i]) begin n_bad++; $display("FAIL %s rd_data[%0d]: got %h want %h", nm, i, rd_obs[i], t_data[i]); end
            end
            n_cmp++;
            if (obs_macks.size() != bx) begin
                n_bad++; $display("FAIL %s master_ack_count: got %0d want %0d", nm, obs_macks.size(), bx);
            end else begin
                for (int i = 0; i < bx; i++) begin
                    n_cmp++;
                    if (obs_macks[i] !== (i == bx - 1)) begin n_bad++; $display("FAIL %s master_ack[%0d]: got %b want %b", nm, i, obs_macks[i], (i == bx - 1)); end
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; rw = 1'b0; dev_addr = 7'h00; nbytes = 4'd0; wr_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({scl_oe, sda_oe, busy, done, ack_err, wr_next, rd_valid} !== 7'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 0000000", {scl_oe, sda_oe, busy, done, ack_err, wr_next, rd_valid});
        end
        n_cmp++;
        if (rd_data !== 8'h00) begin n_bad++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({scl_oe, sda_oe, busy} !== 3'b0) begin n_bad++; $display("FAIL idle_lines: got %b want 000", {scl_oe, sda_oe, busy}); end
    endtask

    task automatic test_write();
        t_addr = 7'h50; t_rw = 1'b0; t_nb = 2; t_data[0] = 8'hA5; t_data[1] = 8'h3C; t_data[2] = 8'hEE;
        s_ack_addr = 1'b1; s_nack_at = -1;
        do_txn("write", 0, 0);
    endtask

    task automatic test_addr_nack();
        t_addr = 7'h21; t_rw = 1'b0; t_nb = 2; t_data[0] = 8'h11; t_data[1] = 8'h22;
        s_ack_addr = 1'b0; s_nack_at = -1;
        do_txn("addr_nack", 0, 0);
        s_ack_addr = 1'b1;
    endtask

    task automatic test_read();
        t_addr = 7'h3B; t_rw = 1'b1; t_nb = 2; t_data[0] = 8'h5A; t_data[1] = 8'hC3;
        s_ack_addr = 1'b1; s_nack_at = -1;
        do_txn("read", 0, 0);
    endtask

    task automatic test_probe_busy();
        logic quiet;
        t_addr = 7'h6E; t_rw = 1'b0; t_nb = 0; t_data[0] = 8'h99;
        s_ack_addr = 1'b1; s_nack_at = -1;
        do_txn("probe_ghost", 50, 0);
        quiet = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (busy !== 1'b0 || scl_oe !== 1'b0 || sda_oe !== 1'b0) quiet = 1'b0;
        end
        n_cmp++;
        if (quiet !== 1'b1) begin n_bad++; $display("FAIL start_not_queued: quiet=%b want 1", quiet); end
    endtask

    task automatic test_reset_mid();
        t_addr = 7'h2D; t_rw = 1'b0; t_nb = 3;
        for (int i = 0; i < 16; i++) t_data[i] = 8'($urandom);
        s_ack_addr = 1'b1; s_nack_at = -1;
        @(negedge clk);
        dev_addr = t_addr; rw = 1'b0; nbytes = 4'd3; wr_data = t_data[0]; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wr_data = t_data[1];
        // 214th cycle after accept: phase 53 = write byte, bit 3, SCL low half.
        repeat (214) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || scl_oe !== 1'b1) begin n_bad++; $display("FAIL reset_mid_pre: busy=%b scl_oe=%b want 1 1", busy, scl_oe); end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({scl_oe, sda_oe, busy, ack_err, done} !== 5'b0) begin
            n_bad++; $display("FAIL reset_mid_release: got %b want 00000", {scl_oe, sda_oe, busy, ack_err, done});
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        do_txn("after_reset", 0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            t_addr = 7'($urandom);
            t_rw = 1'($urandom);
            t_nb = int'($urandom % 5);
            for (int i = 0; i < 16; i++) t_data[i] = 8'($urandom);
            s_ack_addr = (($urandom % 6) != 0);
            s_nack_at = (t_nb > 0 && ($urandom % 3) == 0) ? int'($urandom % t_nb) : -1;
            do_txn($sformatf("rand%0d", n), 0, 0);
        end
        s_ack_addr = 1'b1; s_nack_at = -1;
    endtask

`ifdef I2C_CLK_STRETCH_EN
    task automatic test_stretch();
        t_addr = 7'h50; t_rw = 1'b0; t_nb = 2; t_data[0] = 8'hA5; t_data[1] = 8'h3C;
        s_ack_addr = 1'b1; s_nack_at = -1;
        // Cycle 153 is the first clk of address-ACK phase 2.
        do_txn("stretch", 0, 153);
        stretch = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_addr_nack();
        test_read();
        test_probe_busy();
        test_reset_mid();
        test_random();
`ifdef I2C_CLK_STRETCH_EN
        test_stretch();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
